// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundles the fetch port, the data port and the memory-side
// signals of mem_arbiter. The slave modport is the arbiter's view. The master
// modport is the environment's view: it covers both requesters and the memory.
interface mem_arbiter_if;
   logic        i_req_i;
   logic [31:0] i_addr_i;
   logic [31:0] i_rdata_o;
   logic        i_ack_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [31:0] d_rdata_o;
   logic        d_ack_o;
   logic        mem_rd_en_o;
   logic        mem_wr_en_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_data_i;
   logic        mem_ack_i;
   logic        err_o;

   modport slave (
      input  i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
             mem_data_i, mem_ack_i,
      output i_rdata_o, i_ack_o, d_rdata_o, d_ack_o,
             mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o, err_o
   );

   modport master (
      output i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
             mem_data_i, mem_ack_i,
      input  i_rdata_o, i_ack_o, d_rdata_o, d_ack_o,
             mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o, err_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-port (fetch / data) arbiter in front of a single memory.
// Each transaction takes IDLE -> BUSY -> RESP. A BUSY watchdog aborts the
// transaction after TIMEOUT_CYCLES cycles with no mem_ack_i. An aborted
// transaction returns rdata 0 and pulses err_o together with the ack.
// Optional feature: define ARB_ROUND_ROBIN_EN to give ties to the port that
// was not granted last. Without it, the data port wins every tie.
module mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t     state;
   logic       owner_d;   // 1 = data port owns the current transaction
   logic [7:0] busy_cnt;
   logic       grant_d;

`ifdef ARB_ROUND_ROBIN_EN
   logic       last_d;    // 1 = data port was granted last

   // winner selection: a tie goes to the port not served last
   always_comb begin
      if (bus.i_req_i && bus.d_req_i) grant_d = !last_d;
      else                            grant_d = bus.d_req_i;
   end
`else
   // winner selection: the data port has fixed priority
   always_comb begin
      grant_d = bus.d_req_i;
   end
`endif

   // transaction FSM with registered memory, ack, rdata and error outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         owner_d         <= 1'b0;
         busy_cnt        <= '0;
         bus.i_rdata_o   <= '0;
         bus.i_ack_o     <= 1'b0;
         bus.d_rdata_o   <= '0;
         bus.d_ack_o     <= 1'b0;
         bus.mem_rd_en_o <= 1'b0;
         bus.mem_wr_en_o <= 1'b0;
         bus.mem_addr_o  <= '0;
         bus.mem_data_o  <= '0;
         bus.err_o       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d          <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_req_i || bus.d_req_i) begin
                  // The mem_* registers double as the latched transaction.
                  // They are loaded here and cleared again when BUSY ends.
                  owner_d         <= grant_d;
                  busy_cnt        <= '0;
                  bus.mem_addr_o  <= grant_d ? bus.d_addr_i : bus.i_addr_i;
                  bus.mem_data_o  <= grant_d ? bus.d_wdata_i : '0;
                  bus.mem_wr_en_o <= grant_d && bus.d_we_i;
                  bus.mem_rd_en_o <= !(grant_d && bus.d_we_i);
`ifdef ARB_ROUND_ROBIN_EN
                  last_d          <= grant_d;
`endif
                  state           <= BUSY;
               end
            end
            BUSY: begin
               if (bus.mem_ack_i || busy_cnt == TO_LAST) begin
                  bus.mem_rd_en_o <= 1'b0;
                  bus.mem_wr_en_o <= 1'b0;
                  bus.mem_addr_o  <= '0;
                  bus.mem_data_o  <= '0;
                  bus.err_o       <= !bus.mem_ack_i;
                  if (owner_d) begin
                     bus.d_ack_o <= 1'b1;
                     if (!bus.mem_ack_i)        bus.d_rdata_o <= '0;
                     else if (bus.mem_rd_en_o)  bus.d_rdata_o <= bus.mem_data_i;
                  end else begin
                     bus.i_ack_o   <= 1'b1;
                     bus.i_rdata_o <= bus.mem_ack_i ? bus.mem_data_i : '0;
                  end
                  state <= RESP;
               end else begin
                  busy_cnt <= busy_cnt + 8'd1;
               end
            end
            RESP: begin
               bus.i_ack_o <= 1'b0;
               bus.d_ack_o <= 1'b0;
               bus.err_o   <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- checks mem_arbiter (TIMEOUT_CYCLES = 4) in four ways:
// directed transaction vectors, a tie sequence, a reset during BUSY, and
// random traffic compared against a cycle-arithmetic reference model.
// Compile with ARB_ROUND_ROBIN_EN defined to check the round-robin build.
module tb_mem_arbiter;

   localparam int T = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   mem_arbiter_if bus ();

   mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mdata;
      int          ack_delay;   // BUSY cycle index carrying mem_ack_i; >= T means never
      logic        exp_rd;
      logic        exp_wr;
      logic [31:0] exp_mdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_ack_cyc;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.i_req_i = 0; bus.i_addr_i = '0;
      bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
      bus.mem_ack_i = 0; bus.mem_data_i = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_rd_en"}, 32'(bus.mem_rd_en_o), 0);
      chk({tag, "_wr_en"}, 32'(bus.mem_wr_en_o), 0);
      chk({tag, "_addr"},  bus.mem_addr_o, 0);
      chk({tag, "_data"},  bus.mem_data_o, 0);
      chk({tag, "_i_ack"}, 32'(bus.i_ack_o), 0);
      chk({tag, "_d_ack"}, 32'(bus.d_ack_o), 0);
      chk({tag, "_err"},   32'(bus.err_o), 0);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic seen = 1'b0;
      @(posedge clk); #1;
      if (v.is_d) begin
         bus.d_req_i = 1; bus.d_we_i = v.we; bus.d_addr_i = v.addr; bus.d_wdata_i = v.wdata;
      end else begin
         bus.i_req_i = 1; bus.i_addr_i = v.addr;
      end
      bus.mem_data_i = v.mdata;
      bus.mem_ack_i = 0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(posedge clk); #1;
         bus.mem_ack_i = (k - 1 == v.ack_delay);
         @(negedge clk);
         if (k == 1) begin
            chk($sformatf("vec%0d_rd_en", idx), 32'(bus.mem_rd_en_o), 32'(v.exp_rd));
            chk($sformatf("vec%0d_wr_en", idx), 32'(bus.mem_wr_en_o), 32'(v.exp_wr));
            chk($sformatf("vec%0d_addr", idx), bus.mem_addr_o, v.addr);
            chk($sformatf("vec%0d_mdata", idx), bus.mem_data_o, v.exp_mdata);
         end
         chk($sformatf("vec%0d_other_ack", idx), 32'(v.is_d ? bus.i_ack_o : bus.d_ack_o), 0);
         if (v.is_d ? bus.d_ack_o : bus.i_ack_o) begin
            seen = 1'b1;
            chk($sformatf("vec%0d_ack_cycle", idx), k, v.exp_ack_cyc);
            chk($sformatf("vec%0d_rdata", idx), v.is_d ? bus.d_rdata_o : bus.i_rdata_o, v.exp_rdata);
            chk($sformatf("vec%0d_err", idx), 32'(bus.err_o), 32'(v.exp_err));
         end
      end
      if (!seen) chk($sformatf("vec%0d_ack_timeout", idx), 0, 1);
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic tie_seq();
      logic       exp_own[4];
      int         exp_cyc[4] = '{2, 5, 8, 11};
      int         n = 0;
      logic       drop_i = 0, drop_d = 0;
`ifdef ARB_ROUND_ROBIN_EN
      exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
      @(posedge clk); #1;
      bus.i_req_i = 1; bus.i_addr_i = 32'h100;
      bus.d_req_i = 1; bus.d_we_i = 0; bus.d_addr_i = 32'h200;
      bus.mem_ack_i = 1; bus.mem_data_i = 32'h7777_0000;
      for (int cyc = 1; cyc <= 14 && n < 4; cyc++) begin
         @(posedge clk); #1;
         bus.i_req_i = !drop_i; bus.d_req_i = !drop_d;
         drop_i = 0; drop_d = 0;
         @(negedge clk);
         if (bus.i_ack_o || bus.d_ack_o) begin
            chk($sformatf("tie%0d_owner_is_data", n), 32'(bus.d_ack_o), 32'(exp_own[n]));
            chk($sformatf("tie%0d_both_acks", n), 32'(bus.d_ack_o && bus.i_ack_o), 0);
            chk($sformatf("tie%0d_cycle", n), cyc, exp_cyc[n]);
            if (bus.d_ack_o) drop_d = 1; else drop_i = 1;
            n++;
         end
      end
      chk("tie_ack_count", n, 4);
      @(posedge clk); #1;
      idle_inputs();
      repeat (3) @(posedge clk);
   endtask

   task automatic reset_mid_busy();
      @(posedge clk); #1;
      bus.d_req_i = 1; bus.d_we_i = 1; bus.d_addr_i = 32'h60; bus.d_wdata_i = 32'h600D_600D;
      bus.mem_ack_i = 0;
      @(posedge clk);
      @(negedge clk);
      chk("rmb_busy_wr_en", 32'(bus.mem_wr_en_o), 1);
      #2 rst_n = 1'b0;
      #1 chk_outputs_zero("rmb_async");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rmb_restart_wr_en", 32'(bus.mem_wr_en_o), 1);
      chk("rmb_restart_addr", bus.mem_addr_o, 32'h60);
      @(posedge clk); #1;
      bus.mem_ack_i = 1;
      @(posedge clk);
      @(negedge clk);
      chk("rmb_d_ack", 32'(bus.d_ack_o), 1);
      @(posedge clk); #1;
      idle_inputs();
      repeat (2) @(posedge clk);
   endtask

   task automatic random_run(input int cycles);
      logic        m_active = 0, m_own_d = 0, m_we = 0, m_err = 0;
      logic        m_last_d = 1;
      int          m_start = 0, m_ack_at = -1;
      logic [31:0] m_addr = '0, m_wdata = '0, m_i_rd = '0, m_d_rd = '0;
      logic        i_seen = 0, d_seen = 0;
      logic        e_busy, e_ack;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk); #1;
         if (bus.i_req_i && i_seen) bus.i_req_i = 0;
         else if (!bus.i_req_i && $urandom_range(0, 2) == 0) begin
            bus.i_req_i = 1; bus.i_addr_i = $urandom();
         end
         if (bus.d_req_i && d_seen) bus.d_req_i = 0;
         else if (!bus.d_req_i && $urandom_range(0, 2) == 0) begin
            bus.d_req_i = 1; bus.d_we_i = 1'($urandom_range(0, 1));
            bus.d_addr_i = $urandom(); bus.d_wdata_i = bus.d_we_i ? $urandom() : '0;
         end
         bus.mem_ack_i = 1'($urandom_range(0, 1));
         bus.mem_data_i = $urandom();
         @(negedge clk);
         // expectations for this cycle from transaction start / finish times
         e_busy = m_active && m_ack_at < 0 && c > m_start;
         e_ack  = m_active && c == m_ack_at;
         chk("rnd_rd_en", 32'(bus.mem_rd_en_o), 32'(e_busy && !m_we));
         chk("rnd_wr_en", 32'(bus.mem_wr_en_o), 32'(e_busy && m_we));
         chk("rnd_addr", bus.mem_addr_o, e_busy ? m_addr : '0);
         chk("rnd_mdata", bus.mem_data_o, e_busy ? m_wdata : '0);
         chk("rnd_i_ack", 32'(bus.i_ack_o), 32'(e_ack && !m_own_d));
         chk("rnd_d_ack", 32'(bus.d_ack_o), 32'(e_ack && m_own_d));
         chk("rnd_err", 32'(bus.err_o), 32'(e_ack && m_err));
         chk("rnd_i_rdata", bus.i_rdata_o, m_i_rd);
         chk("rnd_d_rdata", bus.d_rdata_o, m_d_rd);
         i_seen = bus.i_ack_o;
         d_seen = bus.d_ack_o;
         // advance the model with this cycle's inputs
         if (e_busy) begin
            if (bus.mem_ack_i) begin
               m_ack_at = c + 1; m_err = 0;
               if (!m_own_d) m_i_rd = bus.mem_data_i;
               else if (!m_we) m_d_rd = bus.mem_data_i;
            end else if (c - m_start == T) begin
               m_ack_at = c + 1; m_err = 1;
               if (m_own_d) m_d_rd = '0; else m_i_rd = '0;
            end
         end
         if (e_ack) m_active = 0;
         else if (!m_active && (bus.i_req_i || bus.d_req_i)) begin
            if (bus.i_req_i && bus.d_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
               m_own_d = !m_last_d;
`else
               m_own_d = 1;
`endif
            end else m_own_d = bus.d_req_i;
            m_last_d = m_own_d;
            m_active = 1; m_start = c; m_ack_at = -1;
            m_we    = m_own_d && bus.d_we_i;
            m_addr  = m_own_d ? bus.d_addr_i : bus.i_addr_i;
            m_wdata = m_own_d ? bus.d_wdata_i : '0;
         end
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   initial begin
      //          is_d we addr          wdata         mdata         dly rd wr exp_mdata     exp_rdata     err ack
      vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 0,  1'b1, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 2};
      vecs[1] = '{1'b1, 1'b0, 32'h30, 32'h0,        32'hCAFEF00D, 1,  1'b1, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0, 3};
      vecs[2] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 32'h99999999, 0,  1'b0, 1'b1, 32'h12345678, 32'hCAFEF00D, 1'b0, 2};
      vecs[3] = '{1'b1, 1'b1, 32'h44, 32'hAABBCCDD, 32'h11111111, 99, 1'b0, 1'b1, 32'hAABBCCDD, 32'h0,        1'b1, 5};
      vecs[4] = '{1'b0, 1'b0, 32'h14, 32'h0,        32'h22222222, 99, 1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 5};
      vecs[5] = '{1'b0, 1'b0, 32'h13, 32'h0,        32'h0BADF00D, 3,  1'b1, 1'b0, 32'h0,        32'h0BADF00D, 1'b0, 5};
      vecs[6] = '{1'b1, 1'b0, 32'h50, 32'h0,        32'h13579BDF, 2,  1'b1, 1'b0, 32'h0,        32'h13579BDF, 1'b0, 4};

      idle_inputs();
      rst_n = 1'b0;
      #12;
      chk_outputs_zero("reset");
      chk("reset_i_rdata", bus.i_rdata_o, 0);
      chk("reset_d_rdata", bus.d_rdata_o, 0);
      @(negedge clk);
      rst_n = 1'b1;

      tie_seq();

      do_reset();
      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      reset_mid_busy();

      do_reset();
      random_run(3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
